bram_arbiter: RTL

- Shares one single-write/single-read BRAM among `requesters` clients using round-robin arbitration, at one access per cycle.
- After reset, and on request, it runs a clear sweep that writes zero to every word. Synthesised BRAM has no initial contents, so this sweep is the only guaranteed initialisation.
- Sits between client logic and a bram instance with read_after_write=0 and one-cycle registered read.

---
 rtl/bram_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one simple-dual-port BRAM among several clients.
// Runs a zero-fill sweep after reset and on clear_req before serving requests.
module bram_arbiter #(
    parameter int unsigned requesters = 2,
    parameter int unsigned addr_width = 8,
    parameter int unsigned data_width = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear_req,
    output logic                             init_done,
    input  logic [requesters-1:0]            req_valid,
    input  logic [requesters-1:0]            req_write,
    input  logic [requesters*addr_width-1:0] req_addr,
    input  logic [requesters*data_width-1:0] req_wdata,
    output logic [requesters-1:0]            req_ready,
    output logic [requesters-1:0]            rsp_valid,
    output logic [data_width-1:0]            rsp_data,
    output logic [addr_width-1:0]            mem_waddr,
    output logic [data_width-1:0]            mem_wdata,
    output logic                             mem_we,
    output logic [addr_width-1:0]            mem_raddr,
    input  logic [data_width-1:0]            mem_rdata
);

    localparam int unsigned rr_width = (requesters > 1) ? $clog2(requesters) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state;
    logic [addr_width-1:0]   clear_addr;
    logic [addr_width-1:0]   raddr_hold;
    logic [rr_width-1:0]     rr;

    logic [requesters-1:0]   grant;
    logic                    granted;
    logic                    sel_write;
    logic [rr_width-1:0]     sel_idx;
    logic [addr_width-1:0]   sel_addr;
    logic [data_width-1:0]   sel_wdata;
    int unsigned             idx;

    // Search starts one past the last winner and wraps, so the last winner ranks lowest.
    always_comb begin
        grant     = '0;
        granted   = 1'b0;
        sel_write = 1'b0;
        sel_idx   = rr;
        sel_addr  = '0;
        sel_wdata = '0;
        idx       = 0;
        if (state == RUN) begin
            for (int unsigned k = 1; k <= requesters; k++) begin
                idx = (32'(rr) + k) % requesters;
                if (!granted && req_valid[idx]) begin
                    granted    = 1'b1;
                    grant[idx] = 1'b1;
                    sel_idx    = rr_width'(idx);
                    sel_write  = req_write[idx];
                    sel_addr   = req_addr[idx*addr_width +: addr_width];
                    sel_wdata  = req_wdata[idx*data_width +: data_width];
                end
            end
        end
    end

    assign req_ready = grant;
    assign init_done = (state == RUN);
    assign rsp_data  = mem_rdata;
    // rst_n gates the sweep write so no stray write reaches the BRAM while reset is held.
    assign mem_we    = (state == CLEAR) ? rst_n : (granted && sel_write);
    assign mem_waddr = (state == CLEAR) ? clear_addr : sel_addr;
    assign mem_wdata = (state == CLEAR) ? '0 : sel_wdata;
    assign mem_raddr = (granted && !sel_write) ? sel_addr : raddr_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clear_addr <= '0;
            raddr_hold <= '0;
            rr         <= rr_width'(requesters - 1);
            rsp_valid  <= '0;
        end else begin
            rsp_valid <= (granted && !sel_write) ? grant : '0;
            if (granted) rr <= sel_idx;
            if (granted && !sel_write) raddr_hold <= sel_addr;
            case (state)
                CLEAR: begin
                    clear_addr <= clear_addr + 1'b1;
                    if (clear_addr == '1) state <= RUN;
                end
                RUN: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        clear_addr <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
